// File: rtl/sim_status_dev.sv
// Memory-mapped simulation status responder: TOHOST pass/fail, cycle watchdog, console FIFO.
// Optional retired-instruction counter at offset 0x10 enabled by macro SIM_STATUS_INSTRET_EN.
module sim_status_dev #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned MAX_CYCLES    = 1000,
    parameter int unsigned CONSOLE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic [31:0] rsp_rdata,
    output logic        hit,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycle_count,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    input  logic        instret_inc
);

    localparam int unsigned PTR_W = $clog2(CONSOLE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      cycle_q;
    logic [30:0]      fail_code_q;
    logic             overflow_q;
    logic [7:0]       fifo_mem [CONSOLE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] occ_q;

    logic [2:0]  offset_c;
    logic        in_run_c, wr_c;
    logic        tohost_wr_c, tohost_pass_c, tohost_fail_c, timeout_hit_c;
    logic        push_c, pop_c, full_c, push_ok_c;
    logic [31:0] status_c, instret_val_c;

    // Address decode and access qualification
    assign offset_c      = req_addr[4:2];
    assign hit           = req_valid && (req_addr[31:5] == BASE_ADDR[31:5]);
    assign in_run_c      = (state_q == ST_RUN);
    assign wr_c          = hit && req_we;
    assign tohost_wr_c   = in_run_c && wr_c && (offset_c == 3'd0) && (req_be == 4'hF);
    assign tohost_pass_c = tohost_wr_c && (req_wdata == 32'd1);
    assign tohost_fail_c = tohost_wr_c && req_wdata[0] && (req_wdata != 32'd1);
    assign timeout_hit_c = in_run_c && (cycle_q == 32'(MAX_CYCLES - 1));

    assign push_c    = in_run_c && wr_c && (offset_c == 3'd3) && req_be[0];
    assign pop_c     = console_valid && console_ready;
    assign full_c    = (occ_q == CNT_W'(CONSOLE_DEPTH));
    assign push_ok_c = push_c && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // TOHOST pass/fail outranks the watchdog in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (tohost_pass_c)      state_d = ST_PASS;
                else if (tohost_fail_c) state_d = ST_FAIL;
                else if (timeout_hit_c) state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q     <= '0;
            fail_code_q <= '0;
        end else begin
            if (in_run_c)      cycle_q     <= cycle_q + 32'd1;
            if (tohost_fail_c) fail_code_q <= req_wdata[31:1];
        end
    end

    // Console FIFO control; a push while full is kept only if the head pops in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok_c && !pop_c)      occ_q <= occ_q + CNT_W'(1);
            else if (!push_ok_c && pop_c) occ_q <= occ_q - CNT_W'(1);
            if (push_c && !push_ok_c) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok_c) fifo_mem[wr_ptr_q] <= req_wdata[7:0];
    end

`ifdef SIM_STATUS_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                      instret_q <= '0;
        else if (in_run_c && instret_inc) instret_q <= instret_q + 32'd1;
    end

    assign instret_val_c = instret_q;

    logic unused_c;
    assign unused_c = &{1'b0, req_addr[1:0]};
`else
    assign instret_val_c = 32'd0;

    logic unused_c;
    assign unused_c = &{1'b0, req_addr[1:0], instret_inc};
`endif

    assign status_c = {21'd0, 7'(occ_q), overflow_q, state_q};

    // Same-cycle load data; the core selects it when hit is high
    always_comb begin
        rsp_rdata = 32'd0;
        if (hit) begin
            case (offset_c)
                3'd1:    rsp_rdata = cycle_q;
                3'd2:    rsp_rdata = status_c;
                3'd4:    rsp_rdata = instret_val_c;
                default: rsp_rdata = 32'd0;
            endcase
        end
    end

    assign done          = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    assign pass          = (state_q == ST_PASS);
    assign timeout       = (state_q == ST_TIMEOUT);
    assign fail_code     = fail_code_q;
    assign cycle_count   = cycle_q;
    assign console_valid = (occ_q != '0);
    assign console_data  = console_valid ? fifo_mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_sim_status_dev.sv
// Directed self-checking bench for sim_status_dev (default parameters).
module tb_sim_status_dev;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic [31:0] rsp_rdata;
    logic        hit, done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;
    logic        instret_inc;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd_val;

    sim_status_dev dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_rdata(rsp_rdata), .hit(hit),
        .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout),
        .cycle_count(cycle_count),
        .console_valid(console_valid), .console_data(console_data),
        .console_ready(console_ready), .instret_inc(instret_inc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset for one edge; returns at the negedge with the device in IDLE
    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        #1;
        data = rsp_rdata;
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_be = be;
        step(1);
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    endtask

    initial begin
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        console_ready = 0; instret_inc = 0; rst_n = 0;
        step(1);

        // Reset state and PASS at RUN cycle 20
        do_reset();
        check("rst_done", 32'(done), 0);
        check("rst_cycle", cycle_count, 0);
        check("rst_cvalid", 32'(console_valid), 0);
        rd(BASE + 32'h08, rd_val); check("rst_status_idle", rd_val, 32'h0);
        step(1);
        rd(BASE + 32'h08, rd_val); check("status_run", rd_val, 32'h1);
        req_valid = 1'b1; req_addr = BASE + 32'h20; #1;
        check("hit_outside", 32'(hit), 0);
        req_addr = BASE + 32'h1C; #1;
        check("hit_inside", 32'(hit), 1);
        req_valid = 1'b0;
        wr(BASE + 32'h20, 32'd1, 4'hF);
        rd(BASE + 32'h08, rd_val); check("store_outside_ignored", rd_val, 32'h1);
        step(20 - 1 - int'(cycle_count) + 1);
        check("cycle_at_20", cycle_count, 20);
        wr(BASE, 32'd1, 4'hF);
        check("pass_done", 32'(done), 1);
        check("pass_pass", 32'(pass), 1);
        check("pass_fcode", 32'(fail_code), 0);
        check("pass_cycle", cycle_count, 21);
        step(5);
        check("pass_cycle_frozen", cycle_count, 21);
        rd(BASE + 32'h08, rd_val); check("pass_status", rd_val, 32'h2);
        rd(BASE + 32'h04, rd_val); check("cycle_reg", rd_val, 32'd21);
        rd(BASE + 32'h00, rd_val); check("tohost_reads0", rd_val, 32'h0);

        // FAIL, stickiness, ignored even and partial stores
        do_reset(); step(1);
        wr(BASE, 32'd2, 4'hF);
        wr(BASE, 32'd1, 4'h1);
        rd(BASE + 32'h08, rd_val); check("even_partial_ignored", rd_val, 32'h1);
        wr(BASE, 32'd7, 4'hF);
        check("fail_done", 32'(done), 1);
        check("fail_pass", 32'(pass), 0);
        check("fail_code", 32'(fail_code), 3);
        wr(BASE, 32'd1, 4'hF);
        rd(BASE + 32'h08, rd_val); check("fail_sticky", rd_val, 32'h3);

        // Watchdog at 1000, then PASS winning on the boundary cycle
        do_reset(); step(1);
        step(999);
        check("to_before", 32'(timeout), 0);
        step(1);
        check("to_fired", 32'(timeout), 1);
        check("to_cycle", cycle_count, 1000);
        rd(BASE + 32'h08, rd_val); check("to_status", rd_val, 32'h4);
        step(3);
        check("to_cycle_frozen", cycle_count, 1000);
        do_reset(); step(1);
        step(999);
        wr(BASE, 32'd1, 4'hF);
        check("edge_pass", 32'(pass), 1);
        check("edge_timeout", 32'(timeout), 0);
        check("edge_cycle", cycle_count, 1000);

        // Console ordering with back-pressure
        do_reset(); step(1);
        wr(BASE + 32'h0C, 32'h4F, 4'h1);
        wr(BASE + 32'h0C, 32'h4B, 4'h1);
        wr(BASE + 32'h0C, 32'h0A, 4'h1);
        wr(BASE + 32'h0C, 32'h55, 4'h2);
        rd(BASE + 32'h08, rd_val); check("con_occ3", rd_val, 32'h31);
        console_ready = 1'b1;
        check("con_b0", 32'(console_data), 32'h4F); step(1);
        rd(BASE + 32'h08, rd_val); check("con_occ2", rd_val, 32'h21);
        check("con_b1", 32'(console_data), 32'h4B); step(1);
        check("con_b2", 32'(console_data), 32'h0A); step(1);
        rd(BASE + 32'h08, rd_val); check("con_occ0", rd_val, 32'h01);
        check("con_empty", 32'(console_valid), 0);
        console_ready = 1'b0;

        // Full FIFO, push+pop while full, overflow
        do_reset(); step(1);
        for (int i = 0; i < 8; i++) wr(BASE + 32'h0C, 32'(i), 4'h1);
        rd(BASE + 32'h08, rd_val); check("full_no_ovf", rd_val, 32'h81);
        console_ready = 1'b1;
        wr(BASE + 32'h0C, 32'hAA, 4'h1);
        console_ready = 1'b0;
        rd(BASE + 32'h08, rd_val); check("full_pushpop", rd_val, 32'h81);
        wr(BASE + 32'h0C, 32'h08, 4'h1);
        wr(BASE + 32'h0C, 32'h09, 4'h1);
        rd(BASE + 32'h08, rd_val); check("full_ovf", rd_val, 32'h89);
        console_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), 32'(console_data), (i == 8) ? 32'hAA : 32'(i));
            step(1);
        end
        check("drain_empty", 32'(console_valid), 0);
        console_ready = 1'b0;

        // Reset while in PASS with bytes queued
        do_reset(); step(1);
        for (int i = 0; i < 4; i++) wr(BASE + 32'h0C, 32'h10 + 32'(i), 4'h1);
        wr(BASE, 32'd1, 4'hF);
        wr(BASE + 32'h0C, 32'h77, 4'h1);
        rd(BASE + 32'h08, rd_val); check("pass_q4_nopush", rd_val, 32'h42);
        do_reset();
        check("rst2_done", 32'(done), 0);
        check("rst2_pass", 32'(pass), 0);
        check("rst2_cycle", cycle_count, 0);
        check("rst2_cvalid", 32'(console_valid), 0);
        check("rst2_cdata", 32'(console_data), 0);
        rd(BASE + 32'h08, rd_val); check("rst2_status", rd_val, 32'h0);
        step(1);
        rd(BASE + 32'h08, rd_val); check("rst2_run", rd_val, 32'h1);

        // Retired-instruction counter
        instret_inc = 1'b1; step(5); instret_inc = 1'b0;
        rd(BASE + 32'h10, rd_val);
`ifdef SIM_STATUS_INSTRET_EN
        check("instret", rd_val, 32'd5);
`else
        check("instret_absent", rd_val, 32'd0);
`endif
        rd(BASE + 32'h14, rd_val); check("unmapped_reads0", rd_val, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
